muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer owning the HI/LO register pair for the 5-stage MIPS core.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a DW-cycle shift-add or restoring-divide loop.
- Generates the pipeline stall that the hazard unit ORs with its other stall sources when a HI/LO access or new mul/div collides with an operation in flight.
- Also services MTHI/MTLO writes and MFHI/MFLO reads.

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/muldiv_seq_md_step.sv | 37 +++
 rtl/muldiv_seq.sv | 112 +++++++++++
 tb/tb_muldiv_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared op codes, sequencer states and operand helpers for the HI/LO
// multiply/divide unit.
package muldiv_seq_pkg;

  localparam int DSIZE = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_RUN  = 2'd1,
    MDS_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_md_step.sv
// One iteration of the mul/div loop: shift-add for multiply, restoring
// trial-subtract for divide. acc is {hi_part, lo_part}.
module md_step #(
  parameter int DW = 32
) (
  input  logic            is_div,
  input  logic [2*DW-1:0] acc,
  input  logic [DW-1:0]   opnd,
  output logic [2*DW-1:0] acc_next
);

  logic [DW:0]   sum;
  logic [DW:0]   rem_sh;
  logic [DW+1:0] diff;

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_next = acc;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    if (is_div) begin
      // Remainder shifted left with the next dividend bit pulled in.
      rem_sh = acc[2*DW-1:DW-1];
      diff   = {1'b0, rem_sh} - {2'b00, opnd};
      if (diff[DW+1])
        acc_next = {acc[2*DW-2:0], 1'b0};
      else
        acc_next = {diff[DW-1:0], acc[DW-2:0], 1'b1};
    end else begin
      sum      = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
      acc_next = {sum, acc[DW-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO
// writes and the stall raised when EX collides with an operation in flight.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DW = DSIZE,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [DW-1:0] wdata,
  input  logic          hilo_rd,
  input  logic          flush,
  output logic          stall,
  output logic          busy,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam logic [CW-1:0] LAST = CW'(DW);

  md_state_e       state;
  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] acc;
  logic [DW-1:0]   opnd;
  logic            is_div;
  logic            res_neg;
  logic            rem_neg;
  logic [2*DW-1:0] acc_next;
  logic            sa;
  logic            sb;
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;

  // Magnitudes go through the unsigned DW-bit path, so -2^(DW-1) is exact.
  assign sa    = op_is_signed(op) & opa[DW-1];
  assign sb    = op_is_signed(op) & opb[DW-1];
  assign mag_a = sa ? -opa : opa;
  assign mag_b = sb ? -opb : opb;

  assign stall = busy & (hilo_rd | hi_we | lo_we | start);

  md_step #(.DW(DW)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MDS_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        MDS_IDLE: begin
          if (start && !flush) begin
            is_div  <= op_is_div(op);
            opnd    <= op_is_div(op) ? mag_b : mag_a;
            acc     <= {{DW{1'b0}}, op_is_div(op) ? mag_a : mag_b};
            // Divide by zero keeps an all-ones quotient unnegated.
            res_neg <= (sa ^ sb) & ~(op_is_div(op) & (opb == '0));
            rem_neg <= sa;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= MDS_RUN;
          end else if (!flush) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MDS_RUN: begin
          // DW steps at cnt 0..DW-1, then one settle cycle at cnt==DW.
          if (cnt == LAST) begin
            state <= MDS_FIX;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        MDS_FIX: begin
          if (is_div) begin
            hi <= rem_neg ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
            lo <= res_neg ? -acc[DW-1:0]    : acc[DW-1:0];
          end else begin
            {hi, lo} <= res_neg ? -acc : acc;
          end
          busy  <= 1'b0;
          state <= MDS_IDLE;
        end
        default: state <= MDS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus pushes expected {hi,lo} into a
// scoreboard; a monitor pops and compares when busy drops.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int DW      = 32;
  localparam int LATENCY = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          hi_we;
  logic          lo_we;
  logic [DW-1:0] wdata;
  logic          hilo_rd;
  logic          flush;
  logic          stall;
  logic          busy;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  typedef struct {
    string         name;
    logic [DW-1:0] exp_hi;
    logic [DW-1:0] exp_lo;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  muldiv_seq #(.DW(DW), .CW(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .hilo_rd (hilo_rd),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles and score the result when busy falls.
  int   busy_cycles = 0;
  logic prev_busy   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy   = 1'b0;
      busy_cycles = 0;
    end else begin
      if (busy) busy_cycles++;
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_hi"}, 64'(hi), 64'(e.exp_hi));
          check({e.name, "_lo"}, 64'(lo), 64'(e.exp_lo));
          check({e.name, "_lat"}, 64'(busy_cycles), 64'(LATENCY));
        end
        busy_cycles = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic launch(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle_timeout", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] eh, input logic [DW-1:0] el);
    exp_t e;
    e.name = name; e.exp_hi = eh; e.exp_lo = el;
    sb_q.push_back(e);
    launch(o, a, b);
    wait_idle();
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hilo_rd = 1'b0; flush = 1'b0;
    #22;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;

    run_op("mult_neg2x3", MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div_m7_2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_m7_2",   MD_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
    run_op("divu_by0",    MD_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_by0_neg", MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("mult_min2",   MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // MULTU with a colliding MFHI/MFLO from cycle 3 until completion.
    begin
      exp_t e;
      e.name = "multu_max"; e.exp_hi = 32'hFFFF_FFFE; e.exp_lo = 32'h0000_0001;
      sb_q.push_back(e);
    end
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1 hilo_rd = 1'b1;
    bad = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(negedge clk);
      if (busy && (stall !== 1'b1 || hi !== 32'h4000_0000)) bad++;
    end
    check("multu_stall_hold", 64'(bad), 64'd0);
    check("multu_stall_release", 64'(stall), 64'd0);
    check("multu_rd_hi", 64'(hi), 64'hFFFF_FFFE);
    @(posedge clk); #1 hilo_rd = 1'b0;

    // MTHI/MTLO together, then masked by flush, then a flushed start.
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mt_lo", 64'(lo), 64'hA5A5_A5A5);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_5A5A; flush = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_flush_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mt_flush_lo", 64'(lo), 64'hA5A5_A5A5);
    start = 1'b1; op = MD_MULT; opa = 32'd5; opb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flushed_start_busy", 64'(busy), 64'd0);

    // Reset in the middle of a MULT, then a fresh MULT.
    launch(MD_MULT, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op("mult_after_rst", MD_MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
